pc_sequencer: RTL and testbench

Multi-cycle program-counter sequencer for the 31-instruction MIPS core. It owns the PC register and runs the instruction-fetch handshake with instruction memory. In the execute cycle it drives the 2-bit select of the external 4-way PC-source mux: NPC, Rs (jr), branch adder (beq/bne) or jump concatenation (j/jal). It commits the mux output into PC, traps on misaligned targets, and counts retired instructions.

---
 rtl/pc_sequencer.sv | 92 +++++++++
 tb/tb_pc_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the multi-cycle MIPS core: owns PC, runs the
// instruction-fetch handshake, drives the PC-source mux select and counts retirements.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic        is_jr,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic        stall,
  input  logic [31:0] pc_next,
  output logic [1:0]  select_signal,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        pc_we,
  output logic        trap,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {BOOT, FETCH, EXEC, TRAP} state_e;

  localparam logic [1:0] SEL_NPC    = 2'b00;
  localparam logic [1:0] SEL_RS     = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;
  localparam logic [1:0] SEL_JUMP   = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic        trap_q, trap_d;
  logic [1:0]  sel;
  logic        we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      retired_q <= 32'd0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    trap_d    = trap_q;
    sel       = SEL_NPC;
    we        = 1'b0;
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: if (fetch_ack) state_d = EXEC;
      EXEC: begin
        if (is_jr)                         sel = SEL_RS;
        else if (is_jump)                  sel = SEL_JUMP;
        else if (is_branch && branch_taken) sel = SEL_BRANCH;
        // A stalled execute never commits or traps, whatever pc_next holds.
        if (!stall) begin
          if (pc_next[1:0] == 2'b00) begin
            we        = 1'b1;
            pc_d      = pc_next;
            retired_d = retired_q + 32'd1;
            state_d   = FETCH;
          end else begin
            trap_d  = 1'b1;
            state_d = TRAP;
          end
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = BOOT;
    endcase
  end

  assign fetch_req     = (state_q == FETCH);
  assign select_signal = sel;
  assign pc_we         = we;
  assign pc            = pc_q;
  assign npc           = pc_q + 32'd4;
  assign trap          = trap_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus pushes expected commits into a
// scoreboard queue, a monitor pops one on every pc_we and compares.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic        fetch_ack;
  logic        is_jr, is_jump, is_branch, branch_taken, stall;
  logic [31:0] pc_next;
  logic [1:0]  select_signal;
  logic [31:0] pc, npc, retired;
  logic        pc_we, trap;

  pc_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_ack(fetch_ack),
    .is_jr(is_jr), .is_jump(is_jump), .is_branch(is_branch),
    .branch_taken(branch_taken), .stall(stall), .pc_next(pc_next),
    .select_signal(select_signal), .pc(pc), .npc(npc), .pc_we(pc_we),
    .trap(trap), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] pc;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_retired = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every commit strobe must match the oldest expected commit.
  always begin
    exp_t e;
    @(negedge clk);
    if (rst === 1'b0 && pc_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pc_we: got pc_we=1 expected no commit (pc_next %h)", pc_next);
      end else begin
        e = sb_q.pop_front();
        chk("commit_select", {30'd0, select_signal}, {30'd0, e.sel});
        @(posedge clk); #1;
        chk("commit_pc", pc, e.pc);
        chk("commit_retired", retired, e.ret);
        chk("commit_fetch_req", {31'd0, fetch_req}, 32'd1);
      end
    end
  end

  task automatic clear_decode();
    is_jr = 1'b0; is_jump = 1'b0; is_branch = 1'b0; branch_taken = 1'b0;
    stall = 1'b0; pc_next = 32'd0;
  endtask

  // Enters with the DUT in FETCH just after a rising edge; leaves in FETCH after the commit.
  task automatic run_instr(input logic jr, input logic jmp, input logic br, input logic tkn,
                           input logic [31:0] target, input logic [1:0] exp_sel,
                           input int ack_delay, input int stall_cyc);
    fetch_ack = 1'b0;
    repeat (ack_delay) begin
      @(negedge clk);
      chk("wait_fetch_req", {31'd0, fetch_req}, 32'd1);
      chk("wait_pc_hold", pc, exp_pc);
      @(posedge clk); #1;
    end
    fetch_ack = 1'b1;
    @(negedge clk);
    chk("fetch_req", {31'd0, fetch_req}, 32'd1);
    chk("npc", npc, exp_pc + 32'd4);
    @(posedge clk); #1;
    fetch_ack = 1'b0;
    is_jr = jr; is_jump = jmp; is_branch = br; branch_taken = tkn; pc_next = target;
    stall = (stall_cyc > 0);
    repeat (stall_cyc) begin
      @(negedge clk);
      chk("stall_pc_we", {31'd0, pc_we}, 32'd0);
      chk("stall_pc_hold", pc, exp_pc);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    exp_retired = exp_retired + 32'd1;
    sb_q.push_back('{sel: exp_sel, pc: target, ret: exp_retired});
    exp_pc = target;
    @(posedge clk); #1;
    clear_decode();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; fetch_ack = 1'b0;
    clear_decode();
    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_pc", pc, RESET_PC);
    chk("reset_fetch_req", {31'd0, fetch_req}, 32'd0);
    chk("reset_retired", retired, 32'd0);
    chk("reset_trap", {31'd0, trap}, 32'd0);
    chk("reset_pc_we", {31'd0, pc_we}, 32'd0);
    chk("reset_select", {30'd0, select_signal}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("boot_fetch_req", {31'd0, fetch_req}, 32'd0);
    @(posedge clk); #1;

    // Sequential flow.
    for (int i = 0; i < 3; i++)
      run_instr(1'b0, 1'b0, 1'b0, 1'b0, exp_pc + 32'd4, 2'b00, 0, 0);

    // Select priority and not-taken branch.
    run_instr(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0100, 2'b01, 0, 0);
    run_instr(1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0200, 2'b11, 0, 0);
    run_instr(1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0300, 2'b10, 0, 0);
    run_instr(1'b0, 1'b0, 1'b1, 1'b0, exp_pc + 32'd4, 2'b00, 0, 0);

    // Fetch wait of 3 cycles, then 2 stall cycles.
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, exp_pc + 32'd4, 2'b00, 3, 2);

    // npc wrap at the top of the address space.
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 2'b11, 0, 0);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, exp_pc + 32'd4, 2'b00, 0, 0);
    chk("npc_wrapped_pc", pc, 32'd0);

    // Misaligned jr, with a stall cycle in front of it.
    fetch_ack = 1'b1;
    @(posedge clk); #1;
    fetch_ack = 1'b0;
    is_jr = 1'b1; pc_next = 32'h0040_0002; stall = 1'b1;
    @(negedge clk);
    chk("stall_over_trap_pc_we", {31'd0, pc_we}, 32'd0);
    chk("stall_over_trap_select", {30'd0, select_signal}, 32'd1);
    @(posedge clk); #1;
    chk("stall_over_trap_trap", {31'd0, trap}, 32'd0);
    stall = 1'b0;
    @(negedge clk);
    chk("misaligned_pc_we", {31'd0, pc_we}, 32'd0);
    @(posedge clk); #1;
    clear_decode();
    @(negedge clk);
    chk("trap_set", {31'd0, trap}, 32'd1);
    chk("trap_pc_hold", pc, exp_pc);
    chk("trap_retired_hold", retired, exp_retired);
    chk("trap_fetch_req", {31'd0, fetch_req}, 32'd0);
    fetch_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("trap_ack_ignored_fetch_req", {31'd0, fetch_req}, 32'd0);
      chk("trap_ack_ignored_pc_we", {31'd0, pc_we}, 32'd0);
      chk("trap_sticky", {31'd0, trap}, 32'd1);
      chk("trap_select", {30'd0, select_signal}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1; fetch_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("trap_reset_trap", {31'd0, trap}, 32'd0);
    chk("trap_reset_pc", pc, RESET_PC);
    chk("trap_reset_retired", retired, 32'd0);
    chk("trap_reset_fetch_req", {31'd0, fetch_req}, 32'd0);
    exp_pc = RESET_PC; exp_retired = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, exp_pc + 32'd4, 2'b00, 1, 0);

    // Reset while waiting on fetch_ack; a late ack during BOOT is ignored.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; fetch_ack = 1'b1;
    exp_pc = RESET_PC; exp_retired = 32'd0;
    @(negedge clk);
    chk("midfetch_reset_fetch_req", {31'd0, fetch_req}, 32'd0);
    chk("midfetch_reset_pc", pc, RESET_PC);
    chk("midfetch_reset_retired", retired, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("late_ack_still_fetch", {31'd0, fetch_req}, 32'd1);
    chk("late_ack_no_commit", {31'd0, pc_we}, 32'd0);
    @(posedge clk); #1;
    fetch_ack = 1'b0;
    is_branch = 1'b1; pc_next = RESET_PC + 32'd4;
    exp_retired = exp_retired + 32'd1;
    sb_q.push_back('{sel: 2'b00, pc: RESET_PC + 32'd4, ret: exp_retired});
    @(posedge clk); #1;
    clear_decode();

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
